priority_encoder_rr_reg: RTL

- Parametrised, registered successor to the combinational 4-to-2 priority encoder.
- Encodes N request lines into a binary index plus a one-hot grant, in fixed-priority or round-robin mode.
- Optional pulse-request latching; valid/ready output handshake that holds a grant until the consumer accepts it.
- Sits between request sources (interrupt or channel flags) and a single downstream consumer.

---
 rtl/priority_encoder_rr_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/priority_encoder_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_rr_reg
// Description : Registered N-way priority encoder. It supports fixed-priority
//               and round-robin arbitration, optional pulse latching and a
//               valid/ready handshake on its output.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_rr_reg #(
    parameter int N         = 4,
    parameter int IDX_W     = $clog2(N),
    parameter int REQ_LATCH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic [N-1:0]     pending
);

    localparam logic [IDX_W-1:0] c_last = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] c_one  = IDX_W'(1);

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_onehot;
    logic [IDX_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_load;
    logic [N-1:0]     w_eff;
    logic [IDX_W-1:0] w_ptr_upd;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_fix_k;
    logic [IDX_W-1:0] w_rr_k;
    logic [IDX_W-1:0] w_k;
    logic [N-1:0]     w_onehot;

    assign w_accept = r_valid & out_ready;
    assign w_load   = ~r_valid | w_accept;

    // The pointer the next decision starts from. It already accounts for a
    // grant being accepted on this edge, so back-to-back grants rotate
    // without repeating the channel that was just served.
    assign w_ptr_upd = (r_idx == '0) ? c_last : (r_idx - c_one);
    assign w_start   = w_accept ? w_ptr_upd : r_ptr;

    generate
        if (REQ_LATCH != 0) begin : g_latch
            logic [N-1:0] w_clr;
            logic [N-1:0] r_pending;

            assign w_clr   = w_accept ? r_onehot : '0;
            assign w_eff   = (r_pending & ~w_clr) | req;
            assign pending = r_pending;

            // Remember request pulses until their grant is accepted.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pending <= '0;
                end else begin
                    r_pending <= (r_pending & ~w_clr) | req;
                end
            end
        end else begin : g_level
            assign w_eff   = req;
            assign pending = '0;
        end
    endgenerate

    // Fixed priority: the highest set index wins.
    always_comb begin
        w_fix_k = '0;
        for (int i = 0; i < N; i++) begin
            if (w_eff[i]) begin
                w_fix_k = IDX_W'(i);
            end
        end
    end

    // Round robin: search downward from w_start with wrap. The loop visits
    // the candidates in reverse order, so the last hit is the first in
    // search order.
    always_comb begin
        int t;
        t      = 0;
        w_rr_k = '0;
        for (int j = N - 1; j >= 0; j--) begin
            t = int'(w_start) - j;
            if (t < 0) begin
                t = t + N;
            end
            if (w_eff[t]) begin
                w_rr_k = IDX_W'(t);
            end
        end
    end

    assign w_k = rr_mode ? w_rr_k : w_fix_k;

    // Decode the winner into a one-hot grant.
    always_comb begin
        w_onehot      = '0;
        w_onehot[w_k] = 1'b1;
    end

    // Grant register. It loads a new decision when it is empty or its grant
    // is accepted. Otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
        end else if (w_load) begin
            if (w_eff == '0) begin
                r_valid  <= 1'b0;
                r_idx    <= '0;
                r_onehot <= '0;
            end else begin
                r_valid  <= 1'b1;
                r_idx    <= w_k;
                r_onehot <= w_onehot;
            end
        end
    end

    // The round-robin pointer moves only when a grant is accepted. It is
    // tracked in both modes so that switching to round robin stays fair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= c_last;
        end else if (w_accept) begin
            r_ptr <= w_ptr_upd;
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;

endmodule
`default_nettype wire
